// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared constants and state type for the sparse HDC encoder
package hdc_pkg;

   localparam int FEATURE_COUNT    = 617;
   localparam int ENCODING_BIT_THR = 309;
   localparam int HV_DIM           = 1024;
   localparam int LANES            = 8;
   localparam int POP_W            = 10;

   localparam int NUM_SLICES = HV_DIM / LANES;
   localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      BUNDLE = 2'd2,
      OUTPUT = 2'd3
   } seq_state_t;

endpackage

// File: rtl/bundler.sv
// rtl/bundler.sv - one combinational lane: popcount of the bound features, then threshold
module bundler
   import hdc_pkg::*;
(
   input  logic [FEATURE_COUNT-1:0] features,
   output logic                     vote
);

   logic [POP_W-1:0] count;

   // FEATURE_COUNT fits in POP_W bits, so the sum never wraps.
   always_comb begin
      count = '0;
      for (int i = 0; i < FEATURE_COUNT; i++) begin
         count = count + POP_W'(features[i]);
      end
      vote = (count >= POP_W'(ENCODING_BIT_THR));
   end

endmodule

// File: rtl/bundle_sequencer.sv
// rtl/bundle_sequencer.sv - walks LANES bundlers across all slices and hands off the packed hypervector
module bundle_sequencer
   import hdc_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic                           slice_req,
   output logic [IDX_W-1:0]               slice_idx,
   input  logic                           slice_ack,
   input  logic [LANES*FEATURE_COUNT-1:0] slice_bits,
   output logic                           hv_valid,
   input  logic                           hv_ready,
   output logic [HV_DIM-1:0]              hv_out
);

   seq_state_t                     state;
   logic [IDX_W-1:0]               idx;
   logic [LANES*FEATURE_COUNT-1:0] slice_q;
   logic [LANES-1:0]               lane_bits;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      bundler u_bundler (
         .features (slice_q[l*FEATURE_COUNT +: FEATURE_COUNT]),
         .vote     (lane_bits[l])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         slice_q   <= '0;
         hv_out    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         slice_req <= 1'b0;
         slice_idx <= '0;
         hv_valid  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            // hv_out deliberately keeps whatever was packed so far
            state     <= IDLE;
            busy      <= 1'b0;
            slice_req <= 1'b0;
            hv_valid  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     hv_out    <= '0;
                     idx       <= '0;
                     slice_idx <= '0;
                     slice_req <= 1'b1;
                     busy      <= 1'b1;
                     state     <= FETCH;
                  end
               end
               FETCH: begin
                  if (slice_ack) begin
                     slice_q   <= slice_bits;
                     slice_req <= 1'b0;
                     state     <= BUNDLE;
                  end
               end
               BUNDLE: begin
                  hv_out[int'(idx)*LANES +: LANES] <= lane_bits;
                  if (idx == IDX_W'(NUM_SLICES - 1)) begin
                     hv_valid <= 1'b1;
                     state    <= OUTPUT;
                  end else begin
                     idx       <= idx + 1'b1;
                     slice_idx <= idx + 1'b1;
                     slice_req <= 1'b1;
                     state     <= FETCH;
                  end
               end
               OUTPUT: begin
                  if (hv_ready) begin
                     hv_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bundle_sequencer.sv
// tb/tb_bundle_sequencer.sv - randomized self-checking bench for bundle_sequencer
module tb_bundle_sequencer;
   import hdc_pkg::*;

   localparam int NS = HV_DIM / LANES;
   localparam int IW = IDX_W;
   localparam int SW = LANES * FEATURE_COUNT;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              slice_ack = 1'b0;
   logic              hv_ready = 1'b0;
   logic [SW-1:0]     slice_bits = '0;
   logic              busy, done, slice_req, hv_valid;
   logic [IW-1:0]     slice_idx;
   logic [HV_DIM-1:0] hv_out;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int src_mode = 0;
   int delay_slice = -1;
   int delay_wait = 0;
   logic [HV_DIM-1:0] exp_hv;

   bundle_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .slice_req  (slice_req),
      .slice_idx  (slice_idx),
      .slice_ack  (slice_ack),
      .slice_bits (slice_bits),
      .hv_valid   (hv_valid),
      .hv_ready   (hv_ready),
      .hv_out     (hv_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   // mode 0: random bits, mode 1: odd lanes all ones, mode 2: threshold edges on slice 0
   function automatic logic [SW-1:0] make_slice(input int idx);
      logic [SW-1:0]            s;
      logic [FEATURE_COUNT-1:0] lane;
      int                       k;
      int                       edges [4] = '{0, 308, 309, 617};
      s = '0;
      for (int l = 0; l < LANES; l++) begin
         lane = '0;
         if (src_mode == 1) begin
            if (l % 2 == 1) lane = '1;
         end else if (src_mode == 2 && idx == 0) begin
            k = (l < 4) ? edges[l] : 0;
            for (int b = 0; b < k; b++) lane[b] = 1'b1;
         end else begin
            for (int b = 0; b < FEATURE_COUNT; b++) lane[b] = 1'($urandom_range(0, 1));
         end
         s[l*FEATURE_COUNT +: FEATURE_COUNT] = lane;
      end
      return s;
   endfunction

   // Pulses start, then plays the slice source until hv_valid or until slice stop_idx is requested.
   task automatic serve(input int stop_idx, output int lat);
      int       next_idx;
      int       req_cnt;
      logic     prev_ack;
      logic [SW-1:0] s;
      next_idx = 0;
      req_cnt  = 0;
      prev_ack = 1'b0;
      exp_hv   = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!hv_valid) begin
         slice_ack = 1'b0;
         if (prev_ack) begin
            total++;
            if (slice_req !== 1'b0) begin
               bad++;
               $display("FAIL req_drop_in_bundle: slice_req=%b required 0 (slice %0d)", slice_req, next_idx - 1);
            end
            prev_ack = 1'b0;
         end else if (slice_req) begin
            total++;
            if (slice_idx !== IW'(next_idx)) begin
               bad++;
               $display("FAIL slice_idx: got %0d required %0d (req cycle %0d)", slice_idx, next_idx, req_cnt);
            end
            if (next_idx == stop_idx) begin
               slice_ack = 1'b0;
               return;
            end
            req_cnt++;
            if (next_idx != delay_slice || req_cnt > delay_wait) begin
               s = make_slice(next_idx);
               slice_bits = s;
               slice_ack  = 1'b1;
               for (int l = 0; l < LANES; l++)
                  exp_hv[next_idx*LANES + l] = ($countones(s[l*FEATURE_COUNT +: FEATURE_COUNT]) >= ENCODING_BIT_THR);
               if (next_idx == delay_slice) begin
                  total++;
                  if (req_cnt != delay_wait + 1) begin
                     bad++;
                     $display("FAIL delayed_req_cycles: got %0d required %0d", req_cnt, delay_wait + 1);
                  end
               end
               next_idx++;
               req_cnt  = 0;
               prev_ack = 1'b1;
            end
         end
         @(posedge clk); #1;
         lat++;
         if (lat > 5000) begin
            total++; bad++;
            $display("FAIL serve_timeout: hv_valid=%b after %0d cycles required 1", hv_valid, lat);
            slice_ack = 1'b0;
            return;
         end
      end
      slice_ack = 1'b0;
   endtask

   task automatic finish_out();
      int base;
      base = done_cnt;
      hv_ready = 1'b1;
      @(posedge clk); #1;
      hv_ready = 1'b0;
      total++;
      if (done !== 1'b1 || hv_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL handshake: done=%b hv_valid=%b busy=%b required 1 0 0", done, hv_valid, busy);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || done_cnt - base != 1) begin
         bad++;
         $display("FAIL done_pulse: done=%b pulses=%0d required 0 and 1", done, done_cnt - base);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || slice_req !== 1'b0 || slice_idx !== '0 ||
          hv_valid !== 1'b0 || hv_out !== '0) begin
         bad++;
         $display("FAIL reset_state: busy=%b done=%b req=%b idx=%0d valid=%b hv_nonzero=%b required all 0",
                  busy, done, slice_req, slice_idx, hv_valid, |hv_out);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_threshold();
      int lat;
      src_mode = 2;
      serve(-1, lat);
      total++;
      if (hv_out[7:0] !== 8'b0000_1100) begin
         bad++;
         $display("FAIL threshold_edges: hv[7:0]=%b required 00001100", hv_out[7:0]);
      end
      total++;
      if (hv_out !== exp_hv) begin
         bad++;
         $display("FAIL threshold_full: hv_out differs from model in %0d bits", $countones(hv_out ^ exp_hv));
      end
      finish_out();
   endtask

   task automatic test_zero_wait();
      int lat;
      logic [HV_DIM-1:0] pat;
      src_mode = 1;
      serve(-1, lat);
      for (int d = 0; d < HV_DIM; d++) pat[d] = d[0];
      total++;
      if (lat != 1 + 2 * NS) begin
         bad++;
         $display("FAIL zero_wait_latency: got %0d required %0d", lat, 1 + 2 * NS);
      end
      total++;
      if (hv_out !== pat) begin
         bad++;
         $display("FAIL pattern_hv: hv_out differs from d[0] pattern in %0d bits", $countones(hv_out ^ pat));
      end
      finish_out();
   endtask

   task automatic test_delayed_ack();
      int lat;
      src_mode    = 0;
      delay_slice = 5;
      delay_wait  = 3;
      serve(-1, lat);
      delay_slice = -1;
      total++;
      if (lat != 1 + 2 * NS + 3) begin
         bad++;
         $display("FAIL delayed_latency: got %0d required %0d", lat, 1 + 2 * NS + 3);
      end
      total++;
      if (hv_out !== exp_hv) begin
         bad++;
         $display("FAIL random_hv: hv_out differs from model in %0d bits", $countones(hv_out ^ exp_hv));
      end
      finish_out();
   endtask

   task automatic test_backpressure();
      int lat;
      int base;
      logic [HV_DIM-1:0] snap;
      src_mode = 0;
      serve(-1, lat);
      snap = hv_out;
      base = done_cnt;
      total++;
      if (snap !== exp_hv) begin
         bad++;
         $display("FAIL bp_hv: hv_out differs from model in %0d bits", $countones(snap ^ exp_hv));
      end
      for (int c = 0; c < 10; c++) begin
         start = (c == 3);
         @(posedge clk); #1;
         start = 1'b0;
         total++;
         if (hv_valid !== 1'b1 || hv_out !== snap || done !== 1'b0 || slice_req !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: cycle %0d valid=%b hv_changed=%b done=%b req=%b required 1 0 0 0",
                     c, hv_valid, hv_out !== snap, done, slice_req);
         end
      end
      total++;
      if (done_cnt != base) begin
         bad++;
         $display("FAIL bp_early_done: pulses=%0d required 0", done_cnt - base);
      end
      finish_out();
      total++;
      if (busy !== 1'b0 || slice_req !== 1'b0) begin
         bad++;
         $display("FAIL bp_start_ignored: busy=%b req=%b required 0 0", busy, slice_req);
      end
   endtask

   task automatic test_abort();
      int lat;
      int base;
      logic [HV_DIM-1:0] partial;
      src_mode = 0;
      base = done_cnt;
      serve(40, lat);
      partial = exp_hv;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || slice_req !== 1'b0 || hv_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_state: busy=%b req=%b valid=%b required 0 0 0", busy, slice_req, hv_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (done_cnt != base || hv_out !== partial) begin
         bad++;
         $display("FAIL abort_aftermath: pulses=%0d hv_diff_bits=%0d required 0 0",
                  done_cnt - base, $countones(hv_out ^ partial));
      end
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || slice_req !== 1'b0) begin
         bad++;
         $display("FAIL abort_beats_start: busy=%b req=%b required 0 0", busy, slice_req);
      end
      serve(-1, lat);
      total++;
      if (hv_out !== exp_hv || lat != 1 + 2 * NS) begin
         bad++;
         $display("FAIL restart_run: lat=%0d hv_diff_bits=%0d required %0d 0",
                  lat, $countones(hv_out ^ exp_hv), 1 + 2 * NS);
      end
      finish_out();
   endtask

   task automatic test_async_reset();
      int lat;
      src_mode = 0;
      serve(3, lat);
      slice_bits = make_slice(3);
      slice_ack  = 1'b1;
      @(posedge clk); #1;
      slice_ack = 1'b0;
      total++;
      if (busy !== 1'b1 || slice_req !== 1'b0) begin
         bad++;
         $display("FAIL pre_reset_bundle: busy=%b req=%b required 1 0", busy, slice_req);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || slice_req !== 1'b0 || slice_idx !== '0 ||
          hv_valid !== 1'b0 || hv_out !== '0) begin
         bad++;
         $display("FAIL async_reset: busy=%b done=%b req=%b idx=%0d valid=%b hv_nonzero=%b required all 0",
                  busy, done, slice_req, slice_idx, hv_valid, |hv_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_zero_wait();
      test_delayed_ack();
      test_backpressure();
      test_abort();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bundle_sequencer.md
# bundle_sequencer

Time-multiplexes a bank of `LANES` bundler instances across all `HV_DIM` dimensions of one encoded hypervector. It fetches one slice of `LANES × FEATURE_COUNT` bound feature bits per request from the upstream bound-vector source. It thresholds each lane into one output bit and packs the results into an `HV_DIM`-bit hypervector register. The finished vector goes downstream over a valid/ready handshake. It sits between the bound-feature memory and the similarity/classifier stage of the sparse HDC encoder.

## Interface
Parameters:
- `FEATURE_COUNT`, 617: bits bundled per dimension (package constant).
- `ENCODING_BIT_THR`, 309: a dimension is 1 when its popcount is ≥ this value (package constant).
- `HV_DIM`, 1024: output hypervector width. Must be a multiple of `LANES`.
- `LANES`, 8: parallel bundler lanes, i.e. dimensions produced per slice.
- Derived: `NUM_SLICES = HV_DIM/LANES`; `IDX_W = max(1, $clog2(NUM_SLICES))`.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle request to encode one hypervector. Honoured only in IDLE.
- `abort`  in  1  synchronous abort. Returns the block to IDLE from any state.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on the cycle the hv_valid/hv_ready handshake completes.
- `slice_req`  out  1  request for the slice selected by `slice_idx`.
- `slice_idx`  out  IDX_W  slice index, 0..NUM_SLICES-1.
- `slice_ack`  in  1  source's response; `slice_bits` are valid in the same cycle.
- `slice_bits`  in  LANES*FEATURE_COUNT  the slice data. Lane `l` occupies `[l*FEATURE_COUNT +: FEATURE_COUNT]`.
- `hv_valid`  out  1  the completed hypervector is on `hv_out`.
- `hv_ready`  in  1  downstream accepts `hv_out`.
- `hv_out`  out  HV_DIM  packed hypervector. Bit `d = idx*LANES + l` comes from slice `idx`, lane `l`.

## Operation
- FSM states: IDLE, FETCH, BUNDLE, OUTPUT.
- IDLE:
  - On `start`: clear the hv register to 0, set idx to 0, go to FETCH.
- FETCH:
  - `slice_req`=1, with `slice_idx` held at idx.
  - On `slice_ack`: capture `slice_bits` into the slice register and go to BUNDLE.
  - If the source responds in the cycle `slice_req` first rises, that ack counts.
- BUNDLE:
  - The `LANES` bundlers read the slice register combinationally.
  - Their thresholded bits are written to `hv[idx*LANES +: LANES]`.
  - If idx = NUM_SLICES-1, go to OUTPUT. Otherwise increment idx and go to FETCH.
- OUTPUT:
  - `hv_valid`=1, with `hv_out` held stable.
  - On `hv_ready`: pulse `done` and go to IDLE.
- Arithmetic:
  - Lane popcount is 10 bits wide and cannot saturate, since FEATURE_COUNT < 1024.
  - The comparison is unsigned: sum ≥ ENCODING_BIT_THR gives 1.
- `abort` has priority over every other transition in every state:
  - next state is IDLE; `slice_req` and `hv_valid` are 0 the following cycle; no `done` pulse.
  - `hv_out` keeps its partial contents.
- `start` is ignored outside IDLE, including during OUTPUT.
- `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.
- `slice_ack` outside FETCH is ignored.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `slice_req`=0, `slice_idx`=0, `hv_valid`=0, `hv_out`=0.
- `slice_req`, `slice_idx`, `hv_valid`, `hv_out`, `busy` and `done` are all registered. No combinational path from any input to any output.
- Per slice: FETCH takes 1 + (cycles waiting for ack); BUNDLE takes exactly 1.
- `start` sampled at cycle 0 with zero-wait acks:
  - FETCH begins at cycle 1.
  - `hv_valid` first rises at cycle 1 + 2·NUM_SLICES.
- `slice_req` and `slice_idx` are stable from the first FETCH cycle until `slice_ack` is sampled.
- `slice_req` drops in the BUNDLE cycle.
- `rst_n` asserted mid-run: all registers return to reset values immediately (asynchronous).

## Structure
- Package `hdc_pkg` holds:
  - `FEATURE_COUNT`, `ENCODING_BIT_THR`, `HV_DIM`, `LANES`;
  - the typedef `seq_state_t` (IDLE/FETCH/BUNDLE/OUTPUT);
  - the popcount width constant (10).
- Sub-module: `bundler`, one combinational instance per lane via a generate loop. The sequencer owns all registers.

## Test plan
- Threshold edges, LANES=8, one slice:
  - lanes with popcount 0, 308, 309 and 617 give bits 0, 0, 1, 1;
  - remaining lanes are all-zero;
  - check the first 8 bits of `hv_out` = 8'b0000_1100 (lane 0 at bit 0).
- Zero-wait full run (NUM_SLICES=128): `start` at cycle 0 → `hv_valid` at cycle 257, and `hv_out[d]` = d[0] for the patterned source.
- Ack delayed 3 cycles on slice 5: `slice_req` is high for 4 cycles with `slice_idx`=5 stable, and the total latency grows by 3.
- Backpressure: `hv_ready` held low 10 cycles in OUTPUT, with `start` pulsed meanwhile:
  - `hv_valid` and `hv_out` stay constant and `start` is ignored;
  - `done` pulses exactly once, on the handshake cycle.
- `abort` in FETCH of slice 40: next cycle `busy`=0, `slice_req`=0, no `done`; a following `start` restarts at `slice_idx`=0.
- `rst_n` low during BUNDLE: all outputs read reset values asynchronously, before the next clock edge.
